// File: rtl/pu_pkg.sv
// rtl/pu_pkg.sv - shared widths, FSM encoding and saturating add for the PU activation path
//
// Purpose: constants and helpers shared by the activation accumulator and its
// ReLU/scale/clamp stage. No ports (package).
package pu_pkg;

  localparam int IN_W        = 12;
  localparam int ACC_W       = 16;
  localparam int OUT_W       = 5;
  localparam int SHIFT       = 4;
  localparam int NUM_NEURONS = 8;
  localparam int IDX_W       = $clog2(NUM_NEURONS);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Returns {clamped, sum}. One guard bit catches overflow: when the two top
  // bits of the widened sum disagree the true result left the ACC_W range,
  // and the guard bit tells which rail to clamp to.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) begin
      return {1'b1, (s[ACC_W] ? ACC_MIN : ACC_MAX)};
    end
    return {1'b0, s[ACC_W-1:0]};
  endfunction

endpackage

// File: rtl/pu_relu_sat.sv
// rtl/pu_relu_sat.sv - combinational ReLU, arithmetic right shift and unsigned clamp
//
// Purpose: maps a signed accumulator value to an unsigned activation code.
// Ports:
//   acc  in   ACC_W  signed accumulator value
//   act  out  OUT_W  activation: min(max(acc,0) >>> SHIFT, 2^OUT_W-1)
module pu_relu_sat #(
  parameter int ACC_W = 16,
  parameter int OUT_W = 5,
  parameter int SHIFT = 4
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] act
);

  localparam logic [ACC_W-1:0] ACT_MAX = ACC_W'((1 << OUT_W) - 1);

  logic [ACC_W-1:0] pos;
  logic [ACC_W-1:0] shifted;

  // After ReLU the value is non-negative, so a logical shift equals >>>.
  assign pos     = acc[ACC_W-1] ? '0 : acc;
  assign shifted = pos >> SHIFT;
  assign act     = (shifted > ACT_MAX) ? ACT_MAX[OUT_W-1:0] : shifted[OUT_W-1:0];

endmodule

// File: rtl/pu_act_accumulator.sv
// rtl/pu_act_accumulator.sv - accumulates PU partial sums per neuron and emits 5-bit activations
//
// Purpose: sums the 4-tap PU passes of one neuron (saturating), then ReLU,
// shift and clamp, and hands the result downstream over valid/ready.
// Ports:
//   clk, rst      clock (rising edge), synchronous active-high reset
//   in_sum        PU partial sum, signed IN_W
//   in_valid      in_sum valid
//   in_first      first pass of a neuron
//   in_last       last pass of a neuron (may coincide with in_first)
//   in_ready      beat accepted when in_valid & in_ready
//   out_act       activation result
//   out_idx       neuron index of out_act
//   out_valid     result valid, held until out_ready
//   out_ready     consumer accepts on out_valid & out_ready
//   frame_done    pulse after the last neuron index of a frame is accepted
//   ovf_sticky    accumulator has saturated since reset
//   protocol_err  pulse after a framing violation
module pu_act_accumulator
  import pu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_sum,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             in_last,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_act,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_done,
  output logic             ovf_sticky,
  output logic             protocol_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  state_t           state, state_next;
  logic [ACC_W-1:0] acc, acc_next, in_ext;
  logic [ACC_W:0]   sum_sat;
  logic [OUT_W-1:0] act_new;
  logic             take, capture, clamp, perr_next, release_out;

  // The PU cannot stall, so readiness only drops while a result is waiting.
  assign in_ready    = (state != HOLD) | out_ready;
  assign out_valid   = (state == HOLD);
  assign take        = in_valid & in_ready;
  assign release_out = (state == HOLD) & out_ready;
  assign in_ext      = {{(ACC_W-IN_W){in_sum[IN_W-1]}}, in_sum};
  assign sum_sat     = sat_add(acc, in_ext);

  always_comb begin
    state_next = state;
    acc_next   = acc;
    capture    = 1'b0;
    clamp      = 1'b0;
    perr_next  = 1'b0;
    if (release_out) state_next = IDLE;
    // A beat taken in HOLD is only possible with out_ready, so it follows
    // the IDLE rules just like a beat taken in IDLE.
    if (take) begin
      if (in_first) begin
        acc_next  = in_ext;
        perr_next = (state == ACCUM);
      end else if (state == ACCUM) begin
        acc_next = sum_sat[ACC_W-1:0];
        clamp    = sum_sat[ACC_W];
      end else begin
        perr_next = 1'b1;
      end
      if (in_first || state == ACCUM) begin
        if (in_last) begin
          state_next = HOLD;
          capture    = 1'b1;
        end else begin
          state_next = ACCUM;
        end
      end
    end
  end

  // Activation is computed from the final sum including the last beat, so
  // the result is registered in the same edge that accepts that beat.
  pu_relu_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_relu_sat (
    .acc (acc_next),
    .act (act_new)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      out_act      <= '0;
      out_idx      <= '0;
      frame_done   <= 1'b0;
      ovf_sticky   <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      state        <= state_next;
      acc          <= acc_next;
      protocol_err <= perr_next;
      frame_done   <= release_out && (out_idx == LAST_IDX);
      if (capture) out_act <= act_new;
      if (release_out) out_idx <= (out_idx == LAST_IDX) ? '0 : out_idx + 1'b1;
      if (clamp) ovf_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pu_act_accumulator.sv
// tb/tb_pu_act_accumulator.sv - self-checking bench for pu_act_accumulator
module tb_pu_act_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] in_sum = '0;
  logic        in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic        in_ready;
  logic [4:0]  out_act;
  logic [2:0]  out_idx;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        frame_done, ovf_sticky, protocol_err;

  int checks = 0;
  int errors = 0;

  // Reference model: transaction-level view of the neuron stream.
  bit m_open;     // inside a neuron (a first has been taken, no last yet)
  bit m_pending;  // a result waits for the consumer
  int m_acc;
  int m_act;
  int m_idx;
  bit m_sticky, m_perr, m_fd;

  pu_act_accumulator dut (
    .clk          (clk),
    .rst          (rst),
    .in_sum       (in_sum),
    .in_valid     (in_valid),
    .in_first     (in_first),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out_act      (out_act),
    .out_idx      (out_idx),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .frame_done   (frame_done),
    .ovf_sticky   (ovf_sticky),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int act_of(input int a);
    int r;
    if (a < 0) return 0;
    r = a / 16;
    return (r > 31) ? 31 : r;
  endfunction

  task automatic model_reset();
    m_open = 0; m_pending = 0; m_acc = 0; m_act = 0; m_idx = 0;
    m_sticky = 0; m_perr = 0; m_fd = 0;
  endtask

  task automatic model_edge(input bit v, input int s, input bit f, input bit l, input bit r);
    bit ok;
    ok = v && (!m_pending || r);
    m_perr = 0;
    m_fd = 0;
    if (m_pending && r) begin
      m_pending = 0;
      m_fd = (m_idx == 7);
      m_idx = (m_idx + 1) % 8;
    end
    if (ok) begin
      if (f) begin
        if (m_open) m_perr = 1;
        m_acc = s;
        m_open = 1;
      end else if (m_open) begin
        m_acc = m_acc + s;
        if (m_acc > 32767) begin m_acc = 32767; m_sticky = 1; end
        if (m_acc < -32768) begin m_acc = -32768; m_sticky = 1; end
      end else begin
        m_perr = 1;
      end
      if (m_open && l) begin
        m_pending = 1;
        m_act = act_of(m_acc);
        m_open = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, compare outputs mid-cycle, then advance the model.
  task automatic step(input bit v, input int s, input bit f, input bit l, input bit r);
    in_valid = v; in_sum = s[11:0]; in_first = f; in_last = l; out_ready = r;
    @(negedge clk);
    check("in_ready", {31'd0, in_ready}, {31'd0, (!m_pending || r)});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_pending});
    check("out_act", {27'd0, out_act}, m_act);
    check("out_idx", {29'd0, out_idx}, m_idx);
    check("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
    check("ovf_sticky", {31'd0, ovf_sticky}, {31'd0, m_sticky});
    check("protocol_err", {31'd0, protocol_err}, {31'd0, m_perr});
    @(posedge clk);
    model_edge(v, s, f, l, r);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; in_first = 0; in_last = 0; in_sum = '0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  initial begin
    bit v, f, l, r;
    int s;

    do_reset();
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_out_act", {27'd0, out_act}, 0);
    check("rst_out_idx", {29'd0, out_idx}, 0);
    check("rst_ovf", {31'd0, ovf_sticky}, 0);
    check("rst_perr", {31'd0, protocol_err}, 0);
    check("rst_fd", {31'd0, frame_done}, 0);

    // 1) three passes
    step(1, 100, 1, 0, 1);
    step(1, 60, 0, 0, 1);
    check("t1_not_valid_yet", {31'd0, out_valid}, 0);
    step(1, -20, 0, 1, 0);
    check("t1_valid", {31'd0, out_valid}, 1);
    check("t1_act", {27'd0, out_act}, 8);
    check("t1_idx", {29'd0, out_idx}, 0);
    step(0, 0, 0, 0, 1);

    // 2) ReLU
    step(1, -50, 1, 0, 1);
    step(1, 10, 0, 1, 0);
    check("t2_act", {27'd0, out_act}, 0);
    step(0, 0, 0, 0, 1);

    // 3) clamp to OUT_W
    step(1, 2047, 1, 1, 0);
    check("t3_act", {27'd0, out_act}, 31);
    step(0, 0, 0, 0, 1);

    // 4) accumulator saturation
    for (int i = 0; i < 20; i++) step(1, 2047, i == 0, i == 19, 1);
    check("t4_ovf", {31'd0, ovf_sticky}, 1);
    check("t4_act", {27'd0, out_act}, 31);

    // 5) backpressure: next beat must wait
    step(1, 320, 1, 1, 1);
    for (int i = 0; i < 5; i++) step(1, 160, 1, 1, 0);
    check("t5_held_act", {27'd0, out_act}, 20);
    step(1, 160, 1, 1, 1);
    check("t5_next_act", {27'd0, out_act}, 10);
    step(0, 0, 0, 0, 1);

    // 6) full frame of single-pass neurons
    do_reset();
    for (int k = 0; k < 8; k++) step(1, 16 * k, 1, 1, 1);
    check("t6_idx7", {29'd0, out_idx}, 7);
    check("t6_act7", {27'd0, out_act}, 7);
    step(0, 0, 0, 0, 1);
    check("t6_frame_done", {31'd0, frame_done}, 1);
    check("t6_wrap", {29'd0, out_idx}, 0);
    step(0, 0, 0, 0, 1);
    check("t6_fd_pulse", {31'd0, frame_done}, 0);

    // framing violation in IDLE
    step(1, 5, 0, 0, 1);
    check("t6_perr", {31'd0, protocol_err}, 1);
    check("t6_perr_noout", {31'd0, out_valid}, 0);
    step(0, 0, 0, 0, 1);

    // reset mid-neuron
    step(1, 500, 1, 0, 1);
    step(1, 500, 0, 0, 1);
    do_reset();
    step(1, 500, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    check("t6_rst_noout", {31'd0, out_valid}, 0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 9) < 7);
      f = m_open ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 15) != 0);
      l = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       s = 2047;
        1:       s = -2048;
        default: s = int'($urandom_range(0, 4095)) - 2048;
      endcase
      step(v, s, f, l, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
